// File: rtl/timer_ronde_sequencer.sv
// AXI4-Lite master that runs Timer_ronde patrol rounds without CPU help:
// programs the period, enables the timer, polls expiry and re-arms per round.
module timer_ronde_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int POLL_GAP           = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic                            stop,
  input  logic [31:0]                     round_period,
  input  logic [7:0]                      round_count,
  output logic                            busy,
  output logic                            round_done,
  output logic [7:0]                      rounds_left,
  output logic                            error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [AW-1:0] ADDR_CTRL   = AW'(4'h0);
  localparam logic [AW-1:0] ADDR_PERIOD = AW'(4'h4);
  localparam logic [AW-1:0] ADDR_STATUS = AW'(4'h8);
  localparam logic [DW-1:0] CTRL_DIS    = DW'(0);
  localparam logic [DW-1:0] CTRL_EN     = DW'(1);
  localparam logic [DW-1:0] CTRL_REARM  = DW'(3);
  localparam logic [GW-1:0] GAP_LOAD    = GW'(POLL_GAP - 1);

  // IDLE: waiting for start | WR_PERIOD/WR_EN: setup writes | GAP: poll spacing
  // RD_STATUS: expiry poll | WR_REARM: clear expiry | WR_DIS: disable timer
  typedef enum logic [2:0] {
    IDLE, WR_PERIOD, WR_EN, GAP, RD_STATUS, WR_REARM, WR_DIS
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   awaddr_q, araddr_q;
  logic [DW-1:0]   wdata_q;
  logic            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic            busy_q, round_done_q, error_q, endless_q, stop_pend_q;
  logic [7:0]      rounds_left_q;
  logic [GW-1:0]   gap_cnt_q;
  logic            stop_now;
  logic            unused_rdata;

  assign stop_now     = stop | stop_pend_q;
  assign unused_rdata = ^m_axi_rdata[DW-1:1];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      busy_q        <= 1'b0;
      round_done_q  <= 1'b0;
      error_q       <= 1'b0;
      endless_q     <= 1'b0;
      stop_pend_q   <= 1'b0;
      rounds_left_q <= '0;
      gap_cnt_q     <= '0;
    end else begin
      round_done_q <= 1'b0;
      if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
      if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
      if (arvalid_q && m_axi_arready) arvalid_q <= 1'b0;
      if (stop && state_q != IDLE && state_q != WR_DIS) stop_pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            endless_q     <= (round_count == 8'd0);
            rounds_left_q <= round_count;
            error_q       <= 1'b0;
            stop_pend_q   <= 1'b0;
            busy_q        <= 1'b1;
            awaddr_q      <= ADDR_PERIOD;
            wdata_q       <= DW'(round_period);
            awvalid_q     <= 1'b1;
            wvalid_q      <= 1'b1;
            bready_q      <= 1'b1;
            state_q       <= WR_PERIOD;
          end
        end

        GAP: begin
          if (stop_now) begin
            awaddr_q  <= ADDR_CTRL;
            wdata_q   <= CTRL_DIS;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            bready_q  <= 1'b1;
            state_q   <= WR_DIS;
          end else if (gap_cnt_q == '0) begin
            araddr_q  <= ADDR_STATUS;
            arvalid_q <= 1'b1;
            rready_q  <= 1'b1;
            state_q   <= RD_STATUS;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end

        RD_STATUS: begin
          if (m_axi_rvalid && rready_q) begin
            rready_q <= 1'b0;
            if (m_axi_rresp != 2'b00) begin
              error_q     <= 1'b1;
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
              state_q     <= IDLE;
            end else if (stop_now) begin
              awaddr_q  <= ADDR_CTRL;
              wdata_q   <= CTRL_DIS;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              bready_q  <= 1'b1;
              state_q   <= WR_DIS;
            end else if (m_axi_rdata[0]) begin
              awaddr_q  <= ADDR_CTRL;
              wdata_q   <= CTRL_REARM;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              bready_q  <= 1'b1;
              state_q   <= WR_REARM;
            end else begin
              gap_cnt_q <= GAP_LOAD;
              state_q   <= GAP;
            end
          end
        end

        default: begin
          // All write states share the B-channel completion path.
          if (m_axi_bvalid && bready_q) begin
            bready_q <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              error_q     <= 1'b1;
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
              state_q     <= IDLE;
            end else if (state_q == WR_DIS) begin
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
              state_q     <= IDLE;
            end else begin
              if (state_q == WR_REARM) begin
                round_done_q <= 1'b1;
                if (!endless_q) rounds_left_q <= rounds_left_q - 8'd1;
              end
              if (stop_now || (state_q == WR_REARM && !endless_q && rounds_left_q == 8'd1)) begin
                awaddr_q  <= ADDR_CTRL;
                wdata_q   <= CTRL_DIS;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                bready_q  <= 1'b1;
                state_q   <= WR_DIS;
              end else if (state_q == WR_PERIOD) begin
                awaddr_q  <= ADDR_CTRL;
                wdata_q   <= CTRL_EN;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                bready_q  <= 1'b1;
                state_q   <= WR_EN;
              end else begin
                gap_cnt_q <= GAP_LOAD;
                state_q   <= GAP;
              end
            end
          end
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign round_done    = round_done_q;
  assign rounds_left   = rounds_left_q;
  assign error         = error_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_timer_ronde_sequencer.sv
// Bench for timer_ronde_sequencer: behavioural AXI4-Lite slave, expected
// transaction / round_done queues popped by independent monitors.
module tb_timer_ronde_sequencer;

  localparam int PGAP = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic        start, stop;
  logic [31:0] round_period;
  logic [7:0]  round_count;
  logic        busy, round_done, error;
  logic [7:0]  rounds_left;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  timer_ronde_sequencer #(
    .C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32), .POLL_GAP(PGAP)
  ) dut (
    .ACLK(aclk), .ARESETN(aresetn), .start(start), .stop(stop),
    .round_period(round_period), .round_count(round_count),
    .busy(busy), .round_done(round_done), .rounds_left(rounds_left), .error(error),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [1:0]  bresp_q[$];
  logic        status_q[$];
  logic        status_dflt = 1'b0;
  int          aw_hold = 1, w_hold = 1, ar_hold = 1;
  int          b_count = 0;
  int          n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic sb_txn(input bit wr, input logic [3:0] addr, input logic [31:0] data);
    txn_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL txn: got unexpected %s addr=%0h data=%0h, expected none", wr ? "write" : "read", addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.wr != wr || e.addr !== addr || (wr && e.data !== data)) begin
        n_fail++;
        $display("FAIL txn: got %s addr=%0h data=%0h, expected %s addr=%0h data=%0h",
                 wr ? "write" : "read", addr, data, e.wr ? "write" : "read", e.addr, e.data);
      end
    end
  endtask

  function automatic void push_w(input logic [3:0] addr, input logic [31:0] data);
    txn_t t;
    t.wr = 1'b1; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endfunction

  function automatic void push_r();
    txn_t t;
    t.wr = 1'b0; t.addr = 4'h8; t.data = 32'd0;
    exp_q.push_back(t);
  endfunction

  // AXI write slave: inputs change on negedge, handshakes land on the next posedge
  initial begin : wr_slave
    int aw_cnt, w_cnt;
    bit aw_hs, w_hs, b_hs, aw_done, w_done;
    logic [3:0]  cap_addr;
    logic [31:0] cap_data;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    aw_cnt = 0; w_cnt = 0; aw_hs = 0; w_hs = 0; b_hs = 0; aw_done = 0; w_done = 0;
    cap_addr = 0; cap_data = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        awready = 0; wready = 0; bvalid = 0;
        aw_cnt = 0; w_cnt = 0; aw_hs = 0; w_hs = 0; b_hs = 0; aw_done = 0; w_done = 0;
      end else begin
        if (b_hs) bvalid = 0;
        if (aw_hs) aw_done = 1;
        if (w_hs) w_done = 1;
        if (aw_done && w_done && !bvalid) begin
          if (bresp_q.size() != 0) bresp = bresp_q.pop_front();
          else bresp = 2'b00;
          bvalid = 1; aw_done = 0; w_done = 0; b_count++;
          sb_txn(1'b1, cap_addr, cap_data);
        end
        awready = 0;
        if (awvalid && !aw_done) begin
          if (aw_cnt >= aw_hold - 1) awready = 1; else aw_cnt++;
        end
        wready = 0;
        if (wvalid && !w_done) begin
          if (w_cnt >= w_hold - 1) wready = 1; else w_cnt++;
        end
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
        if (aw_hs) begin cap_addr = awaddr; aw_cnt = 0; end
        if (w_hs)  begin cap_data = wdata;  w_cnt = 0; end
      end
    end
  end

  initial begin : rd_slave
    int ar_cnt;
    bit ar_hs, r_hs, ar_pend;
    logic [3:0] cap_araddr;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    ar_cnt = 0; ar_hs = 0; r_hs = 0; ar_pend = 0; cap_araddr = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        arready = 0; rvalid = 0; ar_cnt = 0; ar_hs = 0; r_hs = 0; ar_pend = 0;
      end else begin
        if (r_hs) rvalid = 0;
        if (ar_hs) ar_pend = 1;
        if (ar_pend && !rvalid) begin
          if (status_q.size() != 0) rdata = {31'd0, status_q.pop_front()};
          else rdata = {31'd0, status_dflt};
          rvalid = 1; ar_pend = 0;
          sb_txn(1'b0, cap_araddr, 32'd0);
        end
        arready = 0;
        if (arvalid && !ar_pend && !rvalid) begin
          if (ar_cnt >= ar_hold - 1) arready = 1; else ar_cnt++;
        end
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        if (ar_hs) begin cap_araddr = araddr; ar_cnt = 0; end
      end
    end
  end

  always @(negedge aclk) begin : rd_mon
    logic [7:0] e;
    if (aresetn && round_done) begin
      n_tests++;
      if (exp_rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL round_done: got pulse with rounds_left=%0d, expected no pulse", rounds_left);
      end else begin
        e = exp_rd_q.pop_front();
        if (rounds_left !== e) begin
          n_fail++;
          $display("FAIL round_done rounds_left: got %0d, expected %0d", rounds_left, e);
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] per, input logic [7:0] cnt);
    @(negedge aclk);
    start = 1; stop = 0; round_period = per; round_count = cnt;
    @(negedge aclk);
    start = 0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_awvalid", {31'd0, awvalid}, 32'd1);
    check("start_wvalid", {31'd0, wvalid}, 32'd1);
    check("start_bready", {31'd0, bready}, 32'd1);
    check("start_prot_strb", {25'd0, awprot, wstrb}, {25'd0, 3'd0, 4'hF});
  endtask

  task automatic wait_idle(input int max);
    int i;
    i = 0;
    while (busy && i < max) begin
      @(negedge aclk);
      i++;
    end
    check("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic sb_empty(input string name);
    check({name, "_txn_left"}, exp_q.size(), 32'd0);
    check({name, "_rd_left"}, exp_rd_q.size(), 32'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int aw_cyc, w_cyc, b0, seen, i;
    start = 0; stop = 0; round_period = 0; round_count = 0;
    repeat (2) @(negedge aclk);
    check("rst_valids", {28'd0, awvalid, wvalid, arvalid, bready}, 32'd0);
    check("rst_rready", {31'd0, rready}, 32'd0);
    check("rst_status", {21'd0, busy, round_done, rounds_left, error, 1'b0}, 32'd0);
    check("rst_addr", {24'd0, awaddr, araddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    aresetn = 1;
    repeat (2) @(negedge aclk);

    // 1: two rounds, STATUS 0,0,1 then 0,1
    status_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    push_w(4'h4, 32'd100); push_w(4'h0, 32'd1);
    push_r(); push_r(); push_r(); push_w(4'h0, 32'd3);
    push_r(); push_r(); push_w(4'h0, 32'd3); push_w(4'h0, 32'd0);
    exp_rd_q.push_back(8'd1); exp_rd_q.push_back(8'd0);
    do_start(32'd100, 8'd2);
    check("t1_rounds_left_init", {24'd0, rounds_left}, 32'd2);
    wait_idle(1000);
    check("t1_rounds_left_end", {24'd0, rounds_left}, 32'd0);
    sb_empty("t1");

    // 2: awready held off 3 cycles
    aw_hold = 3;
    status_q = '{1'b1};
    push_w(4'h4, 32'd7); push_w(4'h0, 32'd1); push_r();
    push_w(4'h0, 32'd3); push_w(4'h0, 32'd0);
    exp_rd_q.push_back(8'd0);
    b0 = b_count;
    do_start(32'd7, 8'd1);
    aw_cyc = 1; w_cyc = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      if (awvalid) aw_cyc++;
      if (wvalid) w_cyc++;
    end
    check("t2_awvalid_cycles", aw_cyc, 32'd3);
    check("t2_wvalid_cycles", w_cyc, 32'd1);
    @(negedge aclk);
    check("t2_one_bresp", b_count - b0, 32'd1);
    wait_idle(1000);
    check("t2_b_total", b_count - b0, 32'd4);
    sb_empty("t2");
    aw_hold = 1;

    // 3: endless mode, stop during GAP
    status_dflt = 1'b1;
    push_w(4'h4, 32'd50); push_w(4'h0, 32'd1);
    push_r(); push_w(4'h0, 32'd3); push_r(); push_w(4'h0, 32'd3);
    exp_rd_q.push_back(8'd0); exp_rd_q.push_back(8'd0);
    do_start(32'd50, 8'd0);
    check("t3_rounds_left_init", {24'd0, rounds_left}, 32'd0);
    seen = 0; i = 0;
    while (seen < 2 && i < 500) begin
      @(negedge aclk);
      if (round_done) seen++;
      i++;
    end
    check("t3_two_rounds", seen, 32'd2);
    push_w(4'h0, 32'd0);
    stop = 1;
    @(negedge aclk);
    stop = 0;
    wait_idle(200);
    sb_empty("t3");
    status_dflt = 1'b0;

    // 4: stop while arvalid is pending; no round counted
    ar_hold = 3;
    status_q = '{1'b1};
    push_w(4'h4, 32'd9); push_w(4'h0, 32'd1); push_r(); push_w(4'h0, 32'd0);
    do_start(32'd9, 8'd2);
    i = 0;
    while (!arvalid && i < 200) begin
      @(negedge aclk);
      i++;
    end
    check("t4_arvalid_seen", {31'd0, arvalid}, 32'd1);
    stop = 1;
    @(negedge aclk);
    stop = 0;
    check("t4_arvalid_held", {31'd0, arvalid}, 32'd1);
    wait_idle(200);
    check("t4_rounds_left", {24'd0, rounds_left}, 32'd2);
    sb_empty("t4");
    ar_hold = 1;

    // 5: SLVERR on the enable write, then a clean restart
    bresp_q = '{2'b00, 2'b10};
    push_w(4'h4, 32'd33); push_w(4'h0, 32'd1);
    do_start(32'd33, 8'd1);
    wait_idle(200);
    check("t5_error_set", {31'd0, error}, 32'd1);
    repeat (10) @(negedge aclk);
    sb_empty("t5a");
    status_q = '{1'b1};
    push_w(4'h4, 32'd34); push_w(4'h0, 32'd1); push_r();
    push_w(4'h0, 32'd3); push_w(4'h0, 32'd0);
    exp_rd_q.push_back(8'd0);
    do_start(32'd34, 8'd1);
    check("t5_error_cleared", {31'd0, error}, 32'd0);
    wait_idle(500);
    check("t5_error_stays", {31'd0, error}, 32'd0);
    sb_empty("t5b");

    // 6: asynchronous reset with awvalid high
    do_start(32'd77, 8'd3);
    aresetn = 0;
    #1;
    check("t6_valids_low", {28'd0, awvalid, wvalid, arvalid, bready}, 32'd0);
    check("t6_status_low", {22'd0, busy, round_done, rounds_left}, 32'd0);
    check("t6_awaddr_wdata", {28'd0, awaddr} | wdata, 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1;
    repeat (10) @(negedge aclk);
    check("t6_idle_after", {30'd0, busy, awvalid}, 32'd0);
    sb_empty("t6a");
    status_q = '{1'b1};
    push_w(4'h4, 32'd5); push_w(4'h0, 32'd1); push_r();
    push_w(4'h0, 32'd3); push_w(4'h0, 32'd0);
    exp_rd_q.push_back(8'd0);
    do_start(32'd5, 8'd1);
    wait_idle(500);
    sb_empty("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ronde_sequencer.md
# timer_ronde_sequencer

Hardware sequencer that drives the Timer_ronde AXI4-Lite slave without processor involvement. On `start` it programs the round period, enables the timer, polls the expiry flag and re-arms the timer for a programmed number of patrol rounds. It pulses `round_done` once per round. It sits between the patrol control logic and the Timer_ronde S00_AXI port as that port's only AXI4-Lite master.

## Interface
- C_M_AXI_ADDR_WIDTH, 4, master address width (Timer_ronde map: 0x0 CTRL, 0x4 PERIOD, 0x8 STATUS, 0xC COUNT)
- C_M_AXI_DATA_WIDTH, 32, master data width
- POLL_GAP, 16, idle cycles between consecutive STATUS reads (≥1)

Ports:
- ACLK  in  1  single clock for the block
- ARESETN  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a sequence; sampled only in IDLE
- stop  in  1  one-cycle request to end the sequence early
- round_period  in  32  timer period, latched on accepted start
- round_count  in  8  number of rounds, latched on accepted start; 0 means endless
- busy  out  1  high in every state except IDLE
- round_done  out  1  one-cycle pulse per completed round
- rounds_left  out  8  remaining rounds; frozen at 0 in endless mode
- error  out  1  sticky; set by a non-OKAY response, cleared on the next accepted start
- m_axi_awaddr / awprot / awvalid / awready  standard AXI4-Lite write-address channel; awprot is tied to 0
- m_axi_wdata / wstrb / wvalid / wready  write-data channel; wstrb is tied to 4'hF
- m_axi_bresp / bvalid / bready  write-response channel
- m_axi_araddr / arprot / arvalid / arready  read-address channel; arprot is tied to 0
- m_axi_rdata / rresp / rvalid / rready  read-data channel

## Operation
- States: IDLE, WR_PERIOD, WR_EN, GAP, RD_STATUS, WR_REARM, WR_DIS.
- Each WR_*/RD_* state performs exactly one AXI4-Lite transaction and advances only after its response.
- IDLE:
  - start with stop low → latch inputs, clear error, go to WR_PERIOD.
  - start and stop in the same cycle → start is ignored.
- WR_PERIOD writes PERIOD = round_period, then goes to WR_EN.
- WR_EN writes CTRL = 0x1, then goes to GAP.
- GAP counts POLL_GAP cycles, then goes to RD_STATUS.
- RD_STATUS reads STATUS:
  - rdata[0]=1 → go to WR_REARM.
  - rdata[0]=0 → go back to GAP.
- WR_REARM writes CTRL = 0x3 (clear expiry, keep enable). After its BRESP:
  - pulse round_done;
  - decrement rounds_left when not in endless mode;
  - if rounds_left reaches 0 → go to WR_DIS, otherwise → go to GAP.
- WR_DIS writes CTRL = 0x0, then goes to IDLE.
- stop:
  - Registered as a pending flag and acted on only at a transaction boundary; an in-flight handshake is never aborted.
  - Seen in GAP, or pending at the end of any transaction → go to WR_DIS.
  - Ignored in WR_DIS and IDLE.
- Error:
  - bresp or rresp ≠ OKAY → set error, go straight to IDLE; no WR_DIS is issued.
  - No rounds are counted for the failing transaction.
- Only one transaction is outstanding at a time.

## Timing
- Reset values:
  - all *valid = 0, bready = 0, rready = 0;
  - awaddr/araddr/wdata = 0;
  - busy = 0, round_done = 0, rounds_left = 0, error = 0;
  - state = IDLE.
- Reset is asynchronous and clears mid-transaction: valids drop immediately.
- Start latency: start accepted in cycle n → awvalid and wvalid both high in cycle n+1; busy high in cycle n+1.
- Write handshake:
  - awvalid and wvalid assert in the same cycle and stay stable until their own ready.
  - Each valid deasserts independently the cycle after its handshake.
  - bready is high from issue until bvalid; state advances the cycle after bvalid & bready.
- Read handshake:
  - arvalid is held until arready.
  - rready is high from issue until rvalid; rdata is sampled on rvalid & rready.
- round_done is exactly one cycle wide, in the cycle after the WR_REARM response.
- The minimum poll period is POLL_GAP + read latency.
- rounds_left updates in the same cycle as round_done.
- busy falls in the cycle after the WR_DIS response (or after the error response).

## Test plan
- Slave always ready, round_period=100, round_count=2, STATUS reads 0,0,1 then 0,1:
  - Write order: PERIOD=100, CTRL=1, CTRL=3, CTRL=3, CTRL=0.
  - Two round_done pulses; rounds_left steps 2→1→0; busy low after the final write.
- awready delayed 3 cycles, wready delayed 0:
  - wvalid drops after 1 cycle, awvalid held 3 cycles.
  - Exactly one B response consumed.
- round_count=0, STATUS=1 on every read:
  - Endless re-arm; rounds_left stays 0.
  - stop asserted during GAP → next write is CTRL=0, then IDLE.
- stop asserted while RD_STATUS has arvalid pending:
  - Read completes normally, then WR_DIS is issued; no round_done even if rdata[0]=1.
- bresp=SLVERR on the WR_EN write:
  - error=1, IDLE next, no further transactions.
  - A new start clears error.
- ARESETN pulled low while awvalid=1:
  - All outputs take their reset values immediately.
  - After release, idle until the next start.
